fadd_exec_pipe: RTL and testbench
=================================

Name: fadd_exec_pipe

Overview:
- Pipelined FP add/sub functional unit for the Tomasulo core.
- Sits between the FP-add reservation station, which issues to it, and the common data bus (CDB) arbiter, which receives its results.
- Registers issued operands and computes the sum with the existing combinational single-precision adder (fpADD_32).
- Carries {valid, tag, result} through LATENCY register stages under global backpressure from the CDB grant.

Parameters:
- TAG_W, 4, width of the reservation-station tag carried with each operation.
- LATENCY, 3, accept-to-cdb_req cycles with no stall; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  reservation station presents an operation.
- issue_ready  out  1  unit accepts this cycle.
- issue_op  in  1  0 = A+B, 1 = A−B.
- issue_tag  in  TAG_W  destination tag.
- issue_a  in  32  operand A, IEEE-754 single.
- issue_b  in  32  operand B, IEEE-754 single.
- flush  in  1  synchronous squash of all in-flight operations (branch mispredict).
- cdb_req  out  1  result valid, requesting the CDB.
- cdb_grant  in  1  arbiter grants the CDB this cycle.
- cdb_tag  out  TAG_W  tag of the presented result.
- cdb_data  out  32  presented result.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0; cdb_req = 0; cdb_tag = 0; cdb_data = 0; busy = 0. Stage data registers cleared to 0.
- After reset deassertion, issue_ready is combinationally 1 (pipeline empty).
- Stages S0..S(LATENCY−1):
  - S0 holds the registered operands: A; B with bit 31 inverted when issue_op = 1; tag.
  - The combinational adder reads S0 only; its output is captured into S1.
  - S1..S(LATENCY−1) are a pure shift of {valid, tag, data}.
  - The last stage drives cdb_req/cdb_tag/cdb_data directly from registers.
- advance = !cdb_req | cdb_grant. When advance = 1, every stage loads from its predecessor and S0 loads the issue port.
- When advance = 0, every stage holds. Bubbles are not collapsed; this is a global stall.
- issue_ready = advance & !flush. Accept = issue_valid & issue_ready. S0.valid loads the value of accept.
- Latency: an op accepted in cycle N raises cdb_req in cycle N+LATENCY when no stall occurs. Throughput is 1 op/cycle with continuous grants.
- A result retires when cdb_req & cdb_grant. The next stage content appears the following cycle.
- While cdb_req = 1 and cdb_grant = 0, cdb_tag and cdb_data are held bit-stable, and issue_ready = 0.
- cdb_grant while cdb_req = 0 is ignored, with no state change.
- flush = 1:
  - At the next edge all valid bits are cleared, including the last stage, even if granted that cycle; a simultaneous grant still counts as retirement for the arbiter.
  - No issue is accepted that cycle.
  - Data registers may keep stale values; cdb_req = 0 the cycle after.
- busy = OR of all stage valid bits, registered-stage derived with no combinational path from inputs.
- Arithmetic is exactly the result of fpADD_32 on (S0.A, S0.B'). The unit does no NaN/Inf/denormal handling; equal-magnitude opposite-sign operands yield bits[30:0] = 0.
- Reset asserted mid-operation discards all in-flight ops with no partial output; the first cdb_req after release comes from a newly accepted op.

Test Plan:
- Single add: A=0x3FC00000 (1.5), B=0x40100000 (2.25), op=0, tag=5, grant tied 1 → cdb_req exactly 3 cycles after accept, cdb_data=0x40700000, cdb_tag=5, one cycle wide.
- Subtract and cancel:
  - A=0x40A00000, B=0x40400000, op=1 → 0x40000000.
  - Back-to-back A=B=0x40000000, op=1 → cdb_data[30:0]=0.
  - Results appear in consecutive cycles, tags in issue order.
- Backpressure: issue 4 ops (tags 1..4) back-to-back, hold cdb_grant=0 for 5 cycles after the first cdb_req → issue_ready=0 and cdb_data/cdb_tag stable throughout. Release the grant → tags 1,2,3,4 retire on 4 consecutive cycles, none lost or duplicated.
- Flush: 3 ops in flight, assert flush for 1 cycle with issue_valid=1 → that issue is not accepted, cdb_req=0 next cycle, busy=0, no old tag ever appears on the CDB.
- Async reset: assert rst_n=0 between clock edges with the pipeline full → cdb_req, busy and the other outputs go to 0 before the next edge. After release, issue_ready=1 and the first result is from a newly issued op.
- LATENCY=2 and LATENCY=8 builds: repeat the single add → cdb_req at N+2 and N+8 respectively with the same data 0x40700000.

Source files
------------

// File: rtl/fadd_exec_pipe.sv
// Pipelined FP32 add/sub unit: S0 holds operands, the adder result lands in S1, and the last stage drives the CDB.
// Accept to cdb_req takes LATENCY cycles. An ungranted request stalls every stage and holds issue_ready low.
module fadd_exec_pipe #(
  parameter int TAG_W   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic             flush,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             busy
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [31:0]      dat;
  } stg_t;

  logic             s0_vld_q, s0_vld_d;
  logic [TAG_W-1:0] s0_tag_q, s0_tag_d;
  logic [31:0]      s0_a_q, s0_a_d;
  logic [31:0]      s0_b_q, s0_b_d;
  stg_t             stg_q [1:LATENCY-1];
  stg_t             stg_d [1:LATENCY-1];
  logic             advance;
  logic             accept;
  logic [31:0]      sum;

  fpADD_32 u_add (
    .a (s0_a_q),
    .b (s0_b_q),
    .y (sum)
  );

  assign advance     = !cdb_req || cdb_grant;
  assign issue_ready = advance && !flush;
  assign accept      = issue_valid && issue_ready;

  assign cdb_req  = stg_q[LATENCY-1].vld;
  assign cdb_tag  = stg_q[LATENCY-1].tag;
  assign cdb_data = stg_q[LATENCY-1].dat;

  always_comb begin
    busy = s0_vld_q;
    for (int i = 1; i < LATENCY; i++) busy = busy | stg_q[i].vld;
  end

  always_comb begin
    s0_vld_d = s0_vld_q;
    s0_tag_d = s0_tag_q;
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    stg_d    = stg_q;
    if (advance) begin
      s0_vld_d = accept;
      s0_tag_d = issue_tag;
      s0_a_d   = issue_a;
      s0_b_d   = {issue_b[31] ^ issue_op, issue_b[30:0]};
      stg_d[1] = '{vld: s0_vld_q, tag: s0_tag_q, dat: sum};
      for (int i = 2; i < LATENCY; i++) stg_d[i] = stg_q[i-1];
    end
    // Squash wins over any shift, including a granted last stage.
    if (flush) begin
      s0_vld_d = 1'b0;
      for (int i = 1; i < LATENCY; i++) stg_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_tag_q <= '0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      for (int i = 1; i < LATENCY; i++) stg_q[i] <= '0;
    end else begin
      s0_vld_q <= s0_vld_d;
      s0_tag_q <= s0_tag_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      for (int i = 1; i < LATENCY; i++) stg_q[i] <= stg_d[i];
    end
  end

endmodule

// Combinational FP32 adder: align, add/subtract, normalise, truncate; no special-value handling.
module fpADD_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0] x, z;
  logic [7:0]  d, e_r;
  logic [27:0] mx, mz, s, norm;
  logic [4:0]  lz;
  logic        unused_bits;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      x = a;
      z = b;
    end else begin
      x = b;
      z = a;
    end
    d  = x[30:23] - z[30:23];
    mx = {1'b0, |x[30:23], x[22:0], 3'b000};
    mz = {1'b0, |z[30:23], z[22:0], 3'b000} >> d;
    s  = (x[31] == z[31]) ? mx + mz : mx - mz;
    lz = '0;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    if (s[27]) begin
      norm = s >> 1;
      e_r  = x[30:23] + 8'd1;
    end else begin
      norm = s << lz;
      e_r  = x[30:23] - {3'b000, lz};
    end
    if (s == '0) y = '0;
    else         y = {x[31], e_r, norm[25:3]};
  end

  assign unused_bits = ^{norm[27:26], norm[2:0]};

endmodule

// File: tb/tb_fadd_exec_pipe.sv
// Scoreboard bench for fadd_exec_pipe: latency, subtract/cancel, backpressure, flush, async reset.
module tb_fadd_exec_pipe;
  parameter int LAT = 3;
  localparam int TW = 4;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  logic          clk = 0, rst_n = 1, issue_valid = 0, issue_op = 0, flush = 0, cdb_grant = 1;
  logic [TW-1:0] issue_tag = '0;
  logic [31:0]   issue_a = '0, issue_b = '0;
  logic          issue_ready, cdb_req, busy;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;

  fadd_exec_pipe #(.TAG_W(TW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_tag(issue_tag), .issue_a(issue_a), .issue_b(issue_b),
    .flush(flush), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   dat;
    logic [31:0]   msk;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic        last_acc = 0, rnd_gnt = 0;
  logic [31:0] cur_exp = '0, cur_msk = FULL;

  logic        vo [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] va [0:5] = '{32'h3F800000, 32'h3F800000, 32'hBFC00000, 32'h41200000, 32'h42C80000, 32'h40400000};
  logic [31:0] vb [0:5] = '{32'h3F800000, 32'h3F000000, 32'hC0100000, 32'h41A00000, 32'h3E800000, 32'hBF800000};
  logic [31:0] ve [0:5] = '{32'h40000000, 32'h3F000000, 32'hC0700000, 32'hC1200000, 32'h42C88000, 32'h40800000};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_gnt) cdb_grant = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input logic [31:0] exp, input logic [31:0] msk);
    issue_valid = 1; issue_op = op; issue_a = a; issue_b = b; issue_tag = tag;
    cur_exp = exp; cur_msk = msk;
    for (int n = 0; n < 200; n++) begin
      step();
      if (last_acc) return;
    end
    chk("issue_timeout", 0, 1);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!cdb_req && n < 40) begin step(); n++; end
    if (!cdb_req) chk("req_timeout", 0, 1);
  endtask

  always @(posedge clk) cyc++;

  // Retirement compare, then flush squash, then accept push: same order the DUT resolves them.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      last_acc = 0;
    end else begin
      if (cdb_req && cdb_grant) begin
        if (sb_q.size() == 0) chk("cdb_unexpected_result", {cdb_tag, cdb_data}, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_tag", cdb_tag, e.tag);
          chk("sb_data", cdb_data & e.msk, e.dat & e.msk);
        end
      end
      if (flush) sb_q.delete();
      last_acc = issue_valid && issue_ready;
      if (last_acc) sb_q.push_back('{tag: issue_tag, dat: cur_exp, msk: cur_msk});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k, n, prev, nfly;
    nfly = (LAT < 4) ? LAT : 4;
    #1 rst_n = 0;
    #11;
    chk("rst_cdb_req", cdb_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    @(posedge clk); #1 rst_n = 1;
    #1 chk("ready_after_reset", issue_ready, 1);

    // Single add with grant tied high: latency and one-cycle pulse.
    drive(0, 32'h3FC00000, 32'h40100000, 4'd5, 32'h40700000, FULL);
    issue_valid = 0;
    k = 1;
    while (!cdb_req && k < 40) begin step(); k++; end
    chk("add_latency", k, LAT);
    chk("add_tag", cdb_tag, 5);
    chk("add_data", cdb_data, 32'h40700000);
    step();
    chk("add_pulse_width", cdb_req, 0);

    // Subtract, then exact cancellation, back to back.
    drive(1, 32'h40A00000, 32'h40400000, 4'd2, 32'h40000000, FULL);
    drive(1, 32'h40000000, 32'h40000000, 4'd3, 32'h00000000, 32'h7FFFFFFF);
    issue_valid = 0;
    wait_req();
    chk("sub_tag", cdb_tag, 2);
    chk("sub_data", cdb_data, 32'h40000000);
    step();
    chk("cancel_req", cdb_req, 1);
    chk("cancel_tag", cdb_tag, 3);
    chk("cancel_data", cdb_data[30:0], 0);
    step();

    // Mixed vectors under a random grant.
    rnd_gnt = 1;
    for (int i = 0; i < 6; i++) drive(vo[i], va[i], vb[i], 4'(i), ve[i], FULL);
    issue_valid = 0;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) step();
    rnd_gnt = 0; cdb_grant = 1;
    step();
    chk("rnd_drained", sb_q.size(), 0);
    chk("rnd_busy", busy, 0);

    // Backpressure: grant withheld from the first request for 5 further cycles.
    fork
      begin
        for (int i = 1; i <= 4; i++) drive(vo[i-1], va[i-1], vb[i-1], 4'(i), ve[i-1], FULL);
        issue_valid = 0;
      end
      begin
        n = 0;
        while (!cdb_req && n < 40) begin @(posedge clk); #1; n++; end
        cdb_grant = 0;
        chk("bp_first_tag", cdb_tag, 1);
        for (int i = 0; i < 5; i++) begin
          step();
          chk("bp_ready", issue_ready, 0);
          chk("bp_req", cdb_req, 1);
          chk("bp_tag_hold", cdb_tag, 1);
          chk("bp_data_hold", cdb_data, ve[0]);
        end
        cdb_grant = 1;
        prev = cyc;
        for (int j = 0; j < 4; j++) begin
          n = 0;
          while (!cdb_req && n < 40) begin @(posedge clk); #1; n++; end
          chk("bp_order", cdb_tag, j + 1);
          if (j > 0 && j < nfly) chk("bp_consecutive", cyc - prev, 1);
          prev = cyc;
          @(posedge clk); #1;
        end
      end
    join
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
    chk("bp_drained", sb_q.size(), 0);

    // Flush with three ops in flight and an issue offered in the flush cycle.
    for (int i = 0; i < 3; i++) drive(vo[i], va[i], vb[i], 4'(7 + i), ve[i], FULL);
    issue_valid = 1; issue_tag = 4'd10; flush = 1;
    step();
    flush = 0; issue_valid = 0;
    chk("flush_no_accept", last_acc, 0);
    chk("flush_req", cdb_req, 0);
    chk("flush_busy", busy, 0);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("flush_quiet", cdb_req, 0);
    end

    // Asynchronous reset between edges with the pipeline loaded.
    for (int i = 0; i < LAT; i++) drive(vo[i], va[i], vb[i], 4'(11), ve[i], FULL);
    issue_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_req", cdb_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tag", cdb_tag, 0);
    chk("arst_data", cdb_data, 0);
    @(posedge clk); #1 rst_n = 1;
    #1 chk("arst_ready", issue_ready, 1);
    drive(vo[4], va[4], vb[4], 4'd12, ve[4], FULL);
    issue_valid = 0;
    wait_req();
    chk("arst_first_tag", cdb_tag, 12);
    chk("arst_first_data", cdb_data, ve[4]);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
    step();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
